// File: rtl/reaction_tester_multi.sv
// Multi-round reaction timer: random pre-LED delay, false-start and timeout handling,
// last/best tracking in BCD and a scanned DIGITS-wide 7-segment display.
module reaction_tester_multi #(
    parameter int CLK_HZ          = 100_000_000,
    parameter int TICK_HZ         = 10_000,
    parameter int DIGITS          = 4,
    parameter int ROUNDS          = 4,
    parameter int MIN_DELAY_TICKS = 10_000,
    parameter int RAND_BITS       = 13,
    parameter int SCAN_DIV        = 100_000
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              press,
    input  logic              mode,
    output logic              LED,
    output logic              fault,
    output logic              done,
    output logic [3:0]        round,
    output logic [DIGITS-1:0] AN,
    output logic [6:0]        leds,
    output logic              point
);

    // state   | meaning
    // S_WAIT  | random delay before the stimulus, press here is a false start
    // S_GO    | LED lit, BCD reaction count running
    // S_FAULT | false start flagged, dashes shown until the next press
    // S_SHOW  | round result shown, press moves to the next round
    // S_DONE  | all rounds finished, press starts a new session

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int TW       = $clog2(TICK_DIV);
    localparam int SW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW       = $clog2(MIN_DELAY_TICKS + (1 << RAND_BITS)) + 1;
    localparam int DIGW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW       = 4 * DIGITS;

    localparam logic [TW-1:0]   TICK_RELOAD = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0]   SCAN_RELOAD = SW'(SCAN_DIV - 1);
    localparam logic [15:0]     LFSR_SEED   = 16'hACE1;
    localparam logic [DW-1:0]   DLY_RESET   = DW'(MIN_DELAY_TICKS) + DW'(LFSR_SEED[RAND_BITS-1:0]);
    localparam logic [DIGW-1:0] DIG_LAST    = DIGW'(DIGITS - 1);
    localparam logic [6:0]      SEG_DASH    = 7'b100_0000;

    function automatic logic [BW-1:0] all_nines();
        logic [BW-1:0] v;
        v = '0;
        for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'd9;
        return v;
    endfunction

    localparam logic [BW-1:0] ALL9 = all_nines();

    function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    typedef enum logic [2:0] {S_WAIT, S_GO, S_FAULT, S_SHOW, S_DONE} state_t;

    logic            r_rst_meta, r_rst_sync;
    logic            r_press_m, r_press_s, r_press_d;
    logic            r_mode_m, r_mode_s;
    logic [15:0]     r_lfsr;
    state_t          r_state;
    logic [TW-1:0]   r_tick_cnt;
    logic [DW-1:0]   r_dly;
    logic [BW-1:0]   r_cnt, r_last, r_best;
    logic [3:0]      r_round;
    logic            r_led, r_fault, r_done;
    logic [SW-1:0]   r_scan_cnt;
    logic [DIGW-1:0] r_digit;
    logic [DIGITS-1:0] r_an;
    logic [6:0]      r_seg;
    logic            r_point;

    logic            w_press_rise, w_tick;
    logic [DW-1:0]   w_dly_load;
    logic [BW-1:0]   w_disp_val;
    logic            w_dash;
    logic [3:0]      w_nib;
    logic [DIGITS-1:0] w_an_dec;

    // Reset hits the core immediately but is released on a clock edge.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= 1'b1;
        end else begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= r_rst_meta;
        end
    end

    always_ff @(posedge sysclk or posedge r_rst_sync) begin
        if (r_rst_sync) begin
            r_press_m <= 1'b0;
            r_press_s <= 1'b0;
            r_press_d <= 1'b0;
            r_mode_m  <= 1'b0;
            r_mode_s  <= 1'b0;
            r_lfsr    <= LFSR_SEED;
        end else begin
            r_press_m <= press;
            r_press_s <= r_press_m;
            r_press_d <= r_press_s;
            r_mode_m  <= mode;
            r_mode_s  <= r_mode_m;
            r_lfsr    <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_press_rise = r_press_s & ~r_press_d;
    assign w_tick       = (r_tick_cnt == '0);
    assign w_dly_load   = DW'(MIN_DELAY_TICKS) + DW'(r_lfsr[RAND_BITS-1:0]);

    // Every transition reloads the tick timer so each state starts on a full tick period.
    always_ff @(posedge sysclk or posedge r_rst_sync) begin
        if (r_rst_sync) begin
            r_state    <= S_WAIT;
            r_tick_cnt <= TICK_RELOAD;
            r_dly      <= DLY_RESET;
            r_cnt      <= '0;
            r_last     <= '0;
            r_best     <= ALL9;
            r_round    <= 4'd1;
            r_led      <= 1'b0;
            r_fault    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick ? TICK_RELOAD : r_tick_cnt - TW'(1);
            case (r_state)
                S_WAIT: begin
                    if (w_press_rise) begin
                        r_state    <= S_FAULT;
                        r_fault    <= 1'b1;
                        r_tick_cnt <= TICK_RELOAD;
                    end else if (w_tick) begin
                        if (r_dly <= DW'(1)) begin
                            r_state    <= S_GO;
                            r_led      <= 1'b1;
                            r_cnt      <= '0;
                            r_dly      <= '0;
                            r_tick_cnt <= TICK_RELOAD;
                        end else begin
                            r_dly <= r_dly - DW'(1);
                        end
                    end
                end
                S_GO: begin
                    if (w_press_rise) begin
                        r_state    <= S_SHOW;
                        r_led      <= 1'b0;
                        r_last     <= r_cnt;
                        r_tick_cnt <= TICK_RELOAD;
                        if (r_cnt < r_best) r_best <= r_cnt;
                    end else if (w_tick) begin
                        if (r_cnt == ALL9) begin
                            r_state    <= S_SHOW;
                            r_led      <= 1'b0;
                            r_last     <= ALL9;
                            r_tick_cnt <= TICK_RELOAD;
                        end else begin
                            r_cnt <= bcd_inc(r_cnt);
                        end
                    end
                end
                S_FAULT: begin
                    if (w_press_rise) begin
                        r_state    <= S_WAIT;
                        r_fault    <= 1'b0;
                        r_dly      <= w_dly_load;
                        r_tick_cnt <= TICK_RELOAD;
                    end
                end
                S_SHOW: begin
                    if (w_press_rise) begin
                        r_tick_cnt <= TICK_RELOAD;
                        if (r_round == 4'(ROUNDS)) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                            r_round <= r_round + 4'd1;
                            r_dly   <= w_dly_load;
                        end
                    end
                end
                S_DONE: begin
                    if (w_press_rise) begin
                        r_state    <= S_WAIT;
                        r_done     <= 1'b0;
                        r_round    <= 4'd1;
                        r_best     <= ALL9;
                        r_last     <= '0;
                        r_dly      <= w_dly_load;
                        r_tick_cnt <= TICK_RELOAD;
                    end
                end
                default: r_state <= S_WAIT;
            endcase
        end
    end

    // An all-9s best means no valid round yet, so it is shown as dashes.
    always_comb begin
        w_disp_val = r_last;
        w_dash     = 1'b0;
        case (r_state)
            S_GO:    w_disp_val = r_cnt;
            S_FAULT: w_dash     = 1'b1;
            S_SHOW, S_DONE: begin
                if (r_mode_s) begin
                    w_disp_val = r_best;
                    w_dash     = (r_best == ALL9);
                end
            end
            default: w_disp_val = r_last;
        endcase
    end

    always_comb begin
        w_nib = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_digit == DIGW'(i)) w_nib = w_disp_val[4*i +: 4];
        end
    end

    assign w_an_dec = DIGITS'(1) << r_digit;

    // AN, segments and point all derive from the same r_digit, so they stay aligned.
    always_ff @(posedge sysclk or posedge r_rst_sync) begin
        if (r_rst_sync) begin
            r_scan_cnt <= SCAN_RELOAD;
            r_digit    <= '0;
            r_an       <= DIGITS'(1);
            r_seg      <= 7'h3F;
            r_point    <= 1'b0;
        end else begin
            if (r_scan_cnt == '0) begin
                r_scan_cnt <= SCAN_RELOAD;
                r_digit    <= (r_digit == DIG_LAST) ? '0 : r_digit + DIGW'(1);
            end else begin
                r_scan_cnt <= r_scan_cnt - SW'(1);
            end
            r_an    <= w_an_dec;
            r_seg   <= w_dash ? SEG_DASH : seg7(w_nib);
            r_point <= (r_digit == DIGW'(1));
        end
    end

    assign LED   = r_led;
    assign fault = r_fault;
    assign done  = r_done;
    assign round = r_round;
    assign AN    = r_an;
    assign leds  = r_seg;
    assign point = r_point;

endmodule

// File: tb/tb_reaction_tester_multi.sv
// Directed bench for reaction_tester_multi: scaled timing, one task per scenario.
// A second instance with a 2-cycle tick covers the 9999 timeout in few cycles.
module tb_reaction_tester_multi;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b0;
    logic       press  = 1'b0;
    logic       mode   = 1'b0;
    logic       led, fault, done, point;
    logic [3:0] rnd;
    logic [3:0] an;
    logic [6:0] leds;

    logic       reset2 = 1'b0;
    logic       press2 = 1'b0;
    logic       mode2  = 1'b0;
    logic       led2, fault2, done2, point2;
    logic [3:0] rnd2;
    logic [3:0] an2;
    logic [6:0] leds2;

    int         checks   = 0;
    int         failures = 0;
    logic [6:0] cap_seg [4];
    logic       cap_pt  [4];

    always #5 sysclk = ~sysclk;

    reaction_tester_multi #(
        .CLK_HZ(100), .TICK_HZ(10), .DIGITS(4), .ROUNDS(2),
        .MIN_DELAY_TICKS(5), .RAND_BITS(2), .SCAN_DIV(4)
    ) u_dut (
        .sysclk(sysclk), .reset(reset), .press(press), .mode(mode),
        .LED(led), .fault(fault), .done(done), .round(rnd),
        .AN(an), .leds(leds), .point(point)
    );

    reaction_tester_multi #(
        .CLK_HZ(20), .TICK_HZ(10), .DIGITS(4), .ROUNDS(2),
        .MIN_DELAY_TICKS(5), .RAND_BITS(2), .SCAN_DIV(4)
    ) u_dut2 (
        .sysclk(sysclk), .reset(reset2), .press(press2), .mode(mode2),
        .LED(led2), .fault(fault2), .done(done2), .round(rnd2),
        .AN(an2), .leds(leds2), .point(point2)
    );

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int value, input int d);
        int p;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return seg_of((value / p) % 10);
    endfunction

    // Records the segments and point seen while each digit is enabled.
    task automatic capture_display(input bit sel2);
        for (int d = 0; d < 4; d++) begin
            cap_seg[d] = 7'bx;
            cap_pt[d]  = 1'bx;
        end
        repeat (6) @(negedge sysclk);
        for (int k = 0; k < 20; k++) begin
            @(negedge sysclk);
            for (int d = 0; d < 4; d++) begin
                if (!sel2 && an[d]) begin
                    cap_seg[d] = leds;
                    cap_pt[d]  = point;
                end
                if (sel2 && an2[d]) begin
                    cap_seg[d] = leds2;
                    cap_pt[d]  = point2;
                end
            end
        end
    endtask

    task automatic press_pulse();
        @(negedge sysclk);
        press = 1'b1;
        repeat (3) @(negedge sysclk);
        press = 1'b0;
        repeat (3) @(negedge sysclk);
    endtask

    // Called at the negedge after LED rose (edge G); the press is consumed at edge G+c.
    task automatic press_at(input int c);
        repeat (c - 3) @(posedge sysclk);
        @(negedge sysclk);
        press = 1'b1;
        repeat (3) @(negedge sysclk);
        press = 1'b0;
        repeat (3) @(negedge sysclk);
    endtask

    // Press into WAIT, then return the WAIT length in cycles (or -1 if LED never rose).
    task automatic press_and_wait_led(output int gap);
        int n;
        gap = -1;
        n   = 0;
        @(negedge sysclk);
        press = 1'b1;
        while (n < 200) begin
            @(posedge sysclk);
            n++;
            @(negedge sysclk);
            if (n == 3) press = 1'b0;
            if (led === 1'b1) begin
                gap = n - 3;
                break;
            end
        end
        press = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_an;
        reset = 1'b1;
        repeat (3) @(negedge sysclk);
        checks++; if (led !== 1'b0)    begin failures++; $display("FAIL rst_led got=%b exp=0", led); end
        checks++; if (fault !== 1'b0)  begin failures++; $display("FAIL rst_fault got=%b exp=0", fault); end
        checks++; if (done !== 1'b0)   begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
        checks++; if (rnd !== 4'd1)    begin failures++; $display("FAIL rst_round got=%0d exp=1", rnd); end
        checks++; if (an !== 4'b0001)  begin failures++; $display("FAIL rst_an got=%b exp=0001", an); end
        reset = 1'b0;
        // Two sync edges, then 6 ticks of 10 cycles: LED rises on edge 62.
        for (int n = 1; n <= 62; n++) begin
            @(posedge sysclk);
            @(negedge sysclk);
            exp_an = (n < 3) ? 4'b0001 : 4'(1 << (((n - 3) / 4) % 4));
            checks++; if (an !== exp_an) begin failures++; $display("FAIL scan_an n=%0d got=%b exp=%b", n, an, exp_an); end
            checks++; if (point !== (exp_an == 4'b0010)) begin failures++; $display("FAIL scan_point n=%0d got=%b exp=%b", n, point, exp_an == 4'b0010); end
            checks++; if (led !== (n >= 62)) begin failures++; $display("FAIL first_led n=%0d got=%b exp=%b", n, led, n >= 62); end
        end
    endtask

    task automatic test_normal_round();
        press_at(375);
        checks++; if (led !== 1'b0)   begin failures++; $display("FAIL norm_led got=%b exp=0", led); end
        checks++; if (rnd !== 4'd1)   begin failures++; $display("FAIL norm_round got=%0d exp=1", rnd); end
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL norm_fault got=%b exp=0", fault); end
        mode = 1'b0;
        capture_display(1'b0);
        for (int d = 0; d < 4; d++) begin
            checks++; if (cap_seg[d] !== exp_seg(37, d)) begin failures++; $display("FAIL norm_last_seg d=%0d got=%h exp=%h", d, cap_seg[d], exp_seg(37, d)); end
            checks++; if (cap_pt[d] !== (d == 1)) begin failures++; $display("FAIL norm_point d=%0d got=%b exp=%b", d, cap_pt[d], d == 1); end
        end
        mode = 1'b1;
        capture_display(1'b0);
        for (int d = 0; d < 4; d++) begin
            checks++; if (cap_seg[d] !== exp_seg(37, d)) begin failures++; $display("FAIL norm_best_seg d=%0d got=%h exp=%h", d, cap_seg[d], exp_seg(37, d)); end
        end
        mode = 1'b0;
    endtask

    task automatic test_false_start();
        int gap;
        press_pulse();
        press_pulse();
        checks++; if (fault !== 1'b1) begin failures++; $display("FAIL fs_fault got=%b exp=1", fault); end
        checks++; if (led !== 1'b0)   begin failures++; $display("FAIL fs_led got=%b exp=0", led); end
        checks++; if (rnd !== 4'd2)   begin failures++; $display("FAIL fs_round got=%0d exp=2", rnd); end
        capture_display(1'b0);
        for (int d = 0; d < 4; d++) begin
            checks++; if (cap_seg[d] !== 7'h40) begin failures++; $display("FAIL fs_dash d=%0d got=%h exp=40", d, cap_seg[d]); end
        end
        press_and_wait_led(gap);
        checks++; if (!(gap inside {50, 60, 70, 80})) begin failures++; $display("FAIL fs_rewait_gap got=%0d exp=50/60/70/80", gap); end
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL fs_clear got=%b exp=0", fault); end
        checks++; if (rnd !== 4'd2)   begin failures++; $display("FAIL fs_round_kept got=%0d exp=2", rnd); end
    endtask

    task automatic test_session();
        int gap;
        press_at(205);
        checks++; if (led !== 1'b0)  begin failures++; $display("FAIL ses_led got=%b exp=0", led); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL ses_done_early got=%b exp=0", done); end
        press_pulse();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL ses_done got=%b exp=1", done); end
        checks++; if (rnd !== 4'd2)  begin failures++; $display("FAIL ses_round got=%0d exp=2", rnd); end
        mode = 1'b1;
        capture_display(1'b0);
        for (int d = 0; d < 4; d++) begin
            checks++; if (cap_seg[d] !== exp_seg(20, d)) begin failures++; $display("FAIL ses_best d=%0d got=%h exp=%h", d, cap_seg[d], exp_seg(20, d)); end
        end
        mode = 1'b0;
        capture_display(1'b0);
        for (int d = 0; d < 4; d++) begin
            checks++; if (cap_seg[d] !== exp_seg(20, d)) begin failures++; $display("FAIL ses_last d=%0d got=%h exp=%h", d, cap_seg[d], exp_seg(20, d)); end
        end
        press_and_wait_led(gap);
        checks++; if (!(gap inside {50, 60, 70, 80})) begin failures++; $display("FAIL ses_new_gap got=%0d exp=50/60/70/80", gap); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL ses_new_done got=%b exp=0", done); end
        checks++; if (rnd !== 4'd1)  begin failures++; $display("FAIL ses_new_round got=%0d exp=1", rnd); end
    endtask

    // Press consumed on the same edge as tick 38: the count must stay at 37.
    task automatic test_race();
        press_at(380);
        checks++; if (led !== 1'b0) begin failures++; $display("FAIL race_led got=%b exp=0", led); end
        mode = 1'b0;
        capture_display(1'b0);
        for (int d = 0; d < 4; d++) begin
            checks++; if (cap_seg[d] !== exp_seg(37, d)) begin failures++; $display("FAIL race_last d=%0d got=%h exp=%h", d, cap_seg[d], exp_seg(37, d)); end
        end
        mode = 1'b1;
        capture_display(1'b0);
        for (int d = 0; d < 4; d++) begin
            checks++; if (cap_seg[d] !== exp_seg(37, d)) begin failures++; $display("FAIL race_best_reset d=%0d got=%h exp=%h", d, cap_seg[d], exp_seg(37, d)); end
        end
        mode = 1'b0;
    endtask

    task automatic test_reset_mid_go();
        int gap;
        press_and_wait_led(gap);
        checks++; if (!(gap inside {50, 60, 70, 80})) begin failures++; $display("FAIL mid_gap got=%0d exp=50/60/70/80", gap); end
        checks++; if (rnd !== 4'd2) begin failures++; $display("FAIL mid_round_pre got=%0d exp=2", rnd); end
        repeat (15) @(posedge sysclk);
        #3 reset = 1'b1;
        #1;
        checks++; if (led !== 1'b0) begin failures++; $display("FAIL mid_led got=%b exp=0", led); end
        checks++; if (rnd !== 4'd1) begin failures++; $display("FAIL mid_round got=%0d exp=1", rnd); end
        @(negedge sysclk);
        reset = 1'b0;
        repeat (3) @(negedge sysclk);
        checks++; if (led !== 1'b0)   begin failures++; $display("FAIL mid_led_post got=%b exp=0", led); end
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL mid_fault got=%b exp=0", fault); end
    endtask

    task automatic test_timeout();
        int  n;
        bit  seen;
        @(negedge sysclk);
        reset2 = 1'b1;
        repeat (3) @(negedge sysclk);
        reset2 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge sysclk);
            if (led2 === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin failures++; $display("FAIL to_led_rise got=0 exp=1"); end
        // Tick every 2 cycles: tick 9999 saturates, tick 10000 ends the round.
        n = 0;
        while (n < 20100) begin
            @(posedge sysclk);
            n++;
            @(negedge sysclk);
            if (led2 !== 1'b1) break;
        end
        checks++; if (n !== 20000) begin failures++; $display("FAIL to_cycles got=%0d exp=20000", n); end
        checks++; if (done2 !== 1'b0)  begin failures++; $display("FAIL to_done got=%b exp=0", done2); end
        checks++; if (fault2 !== 1'b0) begin failures++; $display("FAIL to_fault got=%b exp=0", fault2); end
        checks++; if (rnd2 !== 4'd1)   begin failures++; $display("FAIL to_round got=%0d exp=1", rnd2); end
        mode2 = 1'b0;
        capture_display(1'b1);
        for (int d = 0; d < 4; d++) begin
            checks++; if (cap_seg[d] !== exp_seg(9999, d)) begin failures++; $display("FAIL to_last d=%0d got=%h exp=%h", d, cap_seg[d], exp_seg(9999, d)); end
        end
        mode2 = 1'b1;
        capture_display(1'b1);
        for (int d = 0; d < 4; d++) begin
            checks++; if (cap_seg[d] !== 7'h40) begin failures++; $display("FAIL to_best_dash d=%0d got=%h exp=40", d, cap_seg[d]); end
        end
    endtask

    initial begin
        #1 reset2 = 1'b1;
        test_reset();
        test_normal_round();
        test_false_start();
        test_session();
        test_race();
        test_reset_mid_go();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
